restoring_divider: RTL and testbench

RESTORING_DIVIDER -- requirements
Module: restoring_divider

---
 rtl/restoring_divider.sv | 135 +++++++++++++
 tb/tb_restoring_divider.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/restoring_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per cycle, WIDTH steps per division.
// Define RESTORING_DIVIDER_ZERO_DET_EN to short-circuit divide-by-zero and raise div_zero.
module restoring_divider #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StDone
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH:0]   rem_q;
    logic [WIDTH-1:0] quo_q;  // dividend bits shift out the top, quotient bits shift in
    logic [WIDTH-1:0] div_q;
    logic [WIDTH-1:0] quotient_q, remainder_q;

    logic             accept, zero_hit, last_step, borrow;
    logic [WIDTH+1:0] shifted, trial;
    logic [WIDTH:0]   step_rem;
    logic [WIDTH-1:0] step_quo;

    assign accept    = start && (state_q != StCalc);
    assign last_step = (state_q == StCalc) && (cnt_q == CW'(WIDTH - 1));

`ifdef RESTORING_DIVIDER_ZERO_DET_EN
    assign zero_hit = accept && (divisor == '0);
`else
    assign zero_hit = 1'b0;
`endif

    // Extra top bit makes the sign of the trial subtraction a clean borrow flag.
    always_comb begin
        shifted  = {rem_q, quo_q[WIDTH-1]};
        trial    = shifted - {2'b00, div_q};
        borrow   = trial[WIDTH+1];
        step_rem = borrow ? shifted[WIDTH:0] : trial[WIDTH:0];
        step_quo = {quo_q[WIDTH-2:0], ~borrow};
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d = zero_hit ? StDone : StCalc;
                end else begin
                    state_d = StIdle;
                end
            end
            StCalc: begin
                if (last_step) begin
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            div_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
        end else if (accept) begin
            cnt_q <= '0;
            rem_q <= '0;
            quo_q <= dividend;
            div_q <= divisor;
            if (zero_hit) begin
                quotient_q  <= '1;
                remainder_q <= dividend;
            end
        end else if (state_q == StCalc) begin
            cnt_q <= cnt_q + CW'(1);
            rem_q <= step_rem;
            quo_q <= step_quo;
            if (last_step) begin
                quotient_q  <= step_quo;
                remainder_q <= step_rem[WIDTH-1:0];
            end
        end
    end

`ifdef RESTORING_DIVIDER_ZERO_DET_EN
    logic dz_q;

    // Sticky until the next completion of either kind.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dz_q <= 1'b0;
        end else if (zero_hit) begin
            dz_q <= 1'b1;
        end else if (last_step) begin
            dz_q <= 1'b0;
        end
    end

    assign div_zero = dz_q;
`else
    assign div_zero = 1'b0;
`endif

    assign busy      = (state_q == StCalc);
    assign done      = (state_q == StDone);
    assign quotient  = quotient_q;
    assign remainder = remainder_q;

endmodule

// File: tb/tb_restoring_divider.sv
// Scoreboard bench for restoring_divider: expected results queued at start, checked on done.
// Honours RESTORING_DIVIDER_ZERO_DET_EN for divide-by-zero latency and flag expectations.
module tb_restoring_divider;

    localparam int unsigned W = 4;
`ifdef RESTORING_DIVIDER_ZERO_DET_EN
    localparam bit ZD = 1'b1;
`else
    localparam bit ZD = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy, done, div_zero;
    logic [W-1:0] quotient, remainder;

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   failures = 0;
    int   lat, bz, lat2, bz2;

    restoring_divider #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        if (b == '0) begin
            e.q  = '1;
            e.r  = a;
            e.dz = ZD;
        end else begin
            e.q  = a / b;
            e.r  = a % b;
            e.dz = 1'b0;
        end
        return e;
    endfunction

    function automatic int exp_lat(input logic [W-1:0] b);
        return (ZD && b == '0) ? 1 : int'(W) + 1;
    endfunction

    function automatic int exp_busy(input logic [W-1:0] b);
        return (ZD && b == '0) ? 0 : int'(W);
    endfunction

    always @(negedge clk) begin
        if (done) begin
            if (sb.size() == 0) begin
                check("spurious_done", 32'(done), 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("quotient", 32'(quotient), 32'(mon_e.q));
                check("remainder", 32'(remainder), 32'(mon_e.r));
                check("div_zero", 32'(div_zero), 32'(mon_e.dz));
            end
        end
    end

    // Call at a negedge; returns at the negedge where done is high.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit inject,
                          output int l, output int nb);
        logic [W-1:0] hq, hr;
        hq       = quotient;
        hr       = remainder;
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        sb.push_back(model(a, b));
        l  = 0;
        nb = 0;
        @(negedge clk);
        l     = 1;
        start = 1'b0;
        while (!done && l < 20) begin
            if (busy) begin
                nb++;
                check("hold_q", 32'(quotient), 32'(hq));
                check("hold_r", 32'(remainder), 32'(hr));
            end
            @(negedge clk);
            l++;
            if (inject && l == 2) begin
                start    = 1'b1;
                dividend = 4'd6;
                divisor  = 4'd3;
            end else begin
                start = 1'b0;
            end
        end
        if (!done) check("done_timeout", 32'(done), 32'd1);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_quotient", 32'(quotient), 32'd0);
        check("rst_remainder", 32'(remainder), 32'd0);
        check("rst_div_zero", 32'(div_zero), 32'd0);
        rst = 1'b0;

        // Start on the first edge after reset release.
        run_op(4'd13, 4'd3, 1'b0, lat, bz);
        check("lat_13_3", 32'(lat), 32'd5);
        check("busy_13_3", 32'(bz), 32'd4);

        @(negedge clk);
        run_op(4'd15, 4'd1, 1'b0, lat, bz);
        run_op(4'd2, 4'd7, 1'b0, lat2, bz2);
        check("lat_15_1", 32'(lat), 32'd5);
        check("lat_b2b", 32'(lat2), 32'd5);
        check("busy_b2b", 32'(bz2), 32'd4);

        @(negedge clk);
        run_op(4'd11, 4'd2, 1'b1, lat, bz);
        check("lat_ignore", 32'(lat), 32'd5);

        @(negedge clk);
        run_op(4'd9, 4'd0, 1'b0, lat, bz);
        check("lat_div0", 32'(lat), 32'(exp_lat(4'd0)));
        check("busy_div0", 32'(bz), 32'(exp_busy(4'd0)));
        repeat (3) @(negedge clk);
        check("dz_sticky", 32'(div_zero), 32'(ZD));
        check("q_sticky", 32'(quotient), 32'd15);

        // Abort a division with reset; no result may appear for it.
        start    = 1'b1;
        dividend = 4'd14;
        divisor  = 4'd4;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("abort_was_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_quotient", 32'(quotient), 32'd0);
        check("abort_remainder", 32'(remainder), 32'd0);
        check("abort_div_zero", 32'(div_zero), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        run_op(4'd14, 4'd4, 1'b0, lat, bz);
        check("lat_after_abort", 32'(lat), 32'd5);

        for (int a = 0; a < 16; a++) begin
            for (int b = 1; b < 16; b++) begin
                run_op(4'(a), 4'(b), 1'b0, lat, bz);
            end
        end

        repeat (8) @(negedge clk);
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
